rom_ssegment: RTL and testbench

ROM_SSEGMENT -- requirements
Module: rom_ssegment

---
 rtl/rom_ssegment.sv | 60 ++++++
 tb/tb_rom_ssegment.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rom_ssegment.sv
// Registered 7-segment decoder: 4-bit code plus point/blank to an {dp,g,f,e,d,c,b,a}
// pattern, with selectable segment polarity and hex/dash handling of codes 10-15.
module rom_ssegment #(
   parameter int ACTIVE_LOW = 1,
   parameter int HEX_EN     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] code,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] seg
);

   localparam logic [7:0] DARK = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

   logic [6:0] w_digit;
   logic [7:0] w_lit;
   logic [7:0] w_pat;
   logic [7:0] r_seg;

   always_comb begin
      w_digit = 7'b0000000;
      case (code)
         4'h0: w_digit = 7'b0111111;
         4'h1: w_digit = 7'b0000110;
         4'h2: w_digit = 7'b1011011;
         4'h3: w_digit = 7'b1001111;
         4'h4: w_digit = 7'b1100110;
         4'h5: w_digit = 7'b1101101;
         4'h6: w_digit = 7'b1111101;
         4'h7: w_digit = 7'b0000111;
         4'h8: w_digit = 7'b1111111;
         4'h9: w_digit = 7'b1101111;
         4'hA: w_digit = (HEX_EN != 0) ? 7'b1110111 : 7'b1000000;
         4'hB: w_digit = (HEX_EN != 0) ? 7'b1111100 : 7'b1000000;
         4'hC: w_digit = (HEX_EN != 0) ? 7'b0111001 : 7'b1000000;
         4'hD: w_digit = (HEX_EN != 0) ? 7'b1011110 : 7'b1000000;
         4'hE: w_digit = (HEX_EN != 0) ? 7'b1111001 : 7'b1000000;
         4'hF: w_digit = (HEX_EN != 0) ? 7'b1110001 : 7'b1000000;
         default: w_digit = 7'b0000000;
      endcase
   end

   // blank overrides both the digit and the decimal point
   assign w_lit = blank ? '0 : {dp, w_digit};
   assign w_pat = (ACTIVE_LOW != 0) ? ~w_lit : w_lit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg <= DARK;
      end else if (en) begin
         r_seg <= w_pat;
      end
   end

   assign seg = r_seg;

endmodule

// File: tb/tb_rom_ssegment.sv
// Bench for rom_ssegment: default and (ACTIVE_LOW=0, HEX_EN=0) instances share stimulus;
// table vectors, hand sequences for hold/reset, and randomized traffic against a model.
module tb_rom_ssegment;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] code;
   logic       dp;
   logic       blank;
   logic [7:0] seg_def;
   logic [7:0] seg_var;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rom_ssegment #(.ACTIVE_LOW(1), .HEX_EN(1)) u_def (
      .clk(clk), .rst(rst), .en(en), .code(code), .dp(dp), .blank(blank), .seg(seg_def)
   );

   rom_ssegment #(.ACTIVE_LOW(0), .HEX_EN(0)) u_var (
      .clk(clk), .rst(rst), .en(en), .code(code), .dp(dp), .blank(blank), .seg(seg_var)
   );

   // Lit masks {g..a} straight from the display table
   logic [6:0] lit_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   function automatic logic [7:0] model(input logic [3:0] c, input logic d, input logic b,
                                        input bit al, input bit hx);
      logic [6:0] m;
      logic [7:0] lit;
      m = lit_tbl[c];
      if (!hx && c > 4'd9) m = 7'b1000000;
      lit = b ? 8'h00 : {d, m};
      return al ? ~lit : lit;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0] code;
      logic       dp;
      logic       blank;
      logic [7:0] exp_def;
   } vec_t;

   vec_t vecs [20];
   logic [7:0] e_def, e_var;

   initial begin
      vecs[0]  = '{4'h0, 1'b0, 1'b0, 8'hC0};
      vecs[1]  = '{4'h1, 1'b0, 1'b0, 8'hF9};
      vecs[2]  = '{4'h2, 1'b0, 1'b0, 8'hA4};
      vecs[3]  = '{4'h3, 1'b0, 1'b0, 8'hB0};
      vecs[4]  = '{4'h4, 1'b0, 1'b0, 8'h99};
      vecs[5]  = '{4'h5, 1'b0, 1'b0, 8'h92};
      vecs[6]  = '{4'h6, 1'b0, 1'b0, 8'h82};
      vecs[7]  = '{4'h7, 1'b0, 1'b0, 8'hF8};
      vecs[8]  = '{4'h8, 1'b0, 1'b0, 8'h80};
      vecs[9]  = '{4'h9, 1'b0, 1'b0, 8'h90};
      vecs[10] = '{4'hA, 1'b0, 1'b0, 8'h88};
      vecs[11] = '{4'hB, 1'b0, 1'b0, 8'h83};
      vecs[12] = '{4'hC, 1'b0, 1'b0, 8'hC6};
      vecs[13] = '{4'hD, 1'b0, 1'b0, 8'hA1};
      vecs[14] = '{4'hE, 1'b0, 1'b0, 8'h86};
      vecs[15] = '{4'hF, 1'b0, 1'b0, 8'h8E};
      vecs[16] = '{4'h0, 1'b1, 1'b0, 8'h40};
      vecs[17] = '{4'h0, 1'b1, 1'b1, 8'hFF};
      vecs[18] = '{4'h8, 1'b1, 1'b1, 8'hFF};
      vecs[19] = '{4'h9, 1'b1, 1'b0, 8'h10};

      // Asynchronous reset before any clock edge
      rst = 1'b1; en = 1'b1; code = 4'h8; dp = 1'b0; blank = 1'b0;
      #1;
      chk("reset_async_def", seg_def, 8'hFF);
      chk("reset_async_var", seg_var, 8'h00);
      @(posedge clk); #1;
      chk("reset_hold_def", seg_def, 8'hFF);
      chk("reset_hold_var", seg_var, 8'h00);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         en = 1'b1; code = vecs[i].code; dp = vecs[i].dp; blank = vecs[i].blank;
         @(posedge clk); #1;
         chk($sformatf("vec%0d_def", i), seg_def, vecs[i].exp_def);
         chk($sformatf("vec%0d_var", i), seg_var,
             model(vecs[i].code, vecs[i].dp, vecs[i].blank, 1'b0, 1'b0));
      end

      // Variant constants for the dash and a plain digit
      @(negedge clk); code = 4'hC; dp = 1'b0; blank = 1'b0;
      @(posedge clk); #1;
      chk("var_dash", seg_var, 8'h40);
      @(negedge clk); code = 4'h5;
      @(posedge clk); #1;
      chk("var_five", seg_var, 8'h6D);

      // Hold with en=0
      @(negedge clk); en = 1'b1; code = 4'h3;
      @(posedge clk); #1;
      chk("hold_load", seg_def, 8'hB0);
      @(negedge clk); en = 1'b0; code = 4'h7; dp = 1'b1; blank = 1'b1;
      @(posedge clk); #1;
      chk("hold_stay1", seg_def, 8'hB0);
      @(posedge clk); #1;
      chk("hold_stay2", seg_def, 8'hB0);
      chk("hold_stay_var", seg_var, 8'h4F);
      @(negedge clk); en = 1'b1; dp = 1'b0; blank = 1'b0;
      @(posedge clk); #1;
      chk("hold_release", seg_def, 8'hF8);

      // Mid-run reset discards the held pattern
      @(negedge clk); code = 4'h5;
      @(posedge clk); #1;
      chk("midrst_pre", seg_def, 8'h92);
      @(negedge clk); en = 1'b0; #2; rst = 1'b1; #1;
      chk("midrst_async_def", seg_def, 8'hFF);
      chk("midrst_async_var", seg_var, 8'h00);
      @(posedge clk); #1;
      chk("midrst_held", seg_def, 8'hFF);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_no_reappear", seg_def, 8'hFF);
      @(negedge clk); en = 1'b1; code = 4'h1;
      @(posedge clk); #1;
      chk("midrst_reload", seg_def, 8'hF9);

      // Randomized traffic with occasional asynchronous resets
      e_def = seg_def === 8'hF9 ? 8'hF9 : 8'hF9;
      e_var = model(4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         rst = 1'b0;
         en = 1'($urandom_range(0, 2) != 0);
         code = 4'($urandom);
         dp = 1'($urandom);
         blank = 1'($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 24) == 0) begin
            #1; rst = 1'b1; #1;
            e_def = 8'hFF; e_var = 8'h00;
            chk("rnd_rst_def", seg_def, e_def);
            chk("rnd_rst_var", seg_var, e_var);
         end else if (en) begin
            e_def = model(code, dp, blank, 1'b1, 1'b1);
            e_var = model(code, dp, blank, 1'b0, 1'b0);
         end
         @(posedge clk); #1;
         chk($sformatf("rnd%0d_def", i), seg_def, e_def);
         chk($sformatf("rnd%0d_var", i), seg_var, e_var);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
